// File: rtl/wt_mem_req_arbiter_if.sv
// Request-side bundle for wt_mem_req_arbiter: I$/D$ req/ack channels, memory valid/ready stream, credit returns.
// The master modport is the arbiter's view; slave is the caches plus memory adapter.
interface wt_mem_req_arbiter_if #(
  parameter int DataWidth = 128
);
  logic                 icache_req_i;
  logic                 icache_ack_o;
  logic [DataWidth-1:0] icache_data_i;
  logic                 dcache_req_i;
  logic                 dcache_ack_o;
  logic [DataWidth-1:0] dcache_data_i;
  logic                 mem_valid_o;
  logic                 mem_ready_i;
  logic [DataWidth-1:0] mem_data_o;
  logic                 mem_src_o;
  logic                 icache_rtrn_i;
  logic                 dcache_rtrn_i;

  modport master (
    input  icache_req_i, icache_data_i, dcache_req_i, dcache_data_i,
    input  mem_ready_i, icache_rtrn_i, dcache_rtrn_i,
    output icache_ack_o, dcache_ack_o, mem_valid_o, mem_data_o, mem_src_o
  );

  modport slave (
    output icache_req_i, icache_data_i, dcache_req_i, dcache_data_i,
    output mem_ready_i, icache_rtrn_i, dcache_rtrn_i,
    input  icache_ack_o, dcache_ack_o, mem_valid_o, mem_data_o, mem_src_o
  );
endinterface

// File: rtl/wt_mem_req_arbiter.sv
// Round-robin merge of I$ and D$ memory requests into one registered valid/ready stream with per-source credits.
// Optional grant/stall statistics counters are built when WT_ARB_STATS_EN is defined.
module wt_mem_req_arbiter #(
  parameter int DataWidth      = 128,
  parameter int MaxOutstanding = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wt_mem_req_arbiter_if.master  bus,
  output logic                  idle_o,
  output logic                  err_o
`ifdef WT_ARB_STATS_EN
  ,
  output logic [31:0]           stat_icache_o,
  output logic [31:0]           stat_dcache_o,
  output logic [31:0]           stat_stall_o
`endif
);

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

  localparam logic [3:0] Limit = 4'(MaxOutstanding);

  // State
  logic [3:0]           cnt_i_q, cnt_i_d;
  logic [3:0]           cnt_d_q, cnt_d_d;
  src_e                 rr_q, rr_d;
  logic                 mem_valid_q, mem_valid_d;
  logic [DataWidth-1:0] mem_data_q, mem_data_d;
  src_e                 mem_src_q, mem_src_d;
  logic                 err_q, err_d;

  // Arbitration terms
  logic slot_free;
  logic elig_i, elig_d;
  logic gnt_i, gnt_d;

  function automatic logic [3:0] credit_next(input logic [3:0] cnt,
                                             input logic       grant,
                                             input logic       rtrn);
    logic [3:0] nxt;
    nxt = cnt;
    if (grant && !rtrn)
      nxt = cnt + 4'd1;
    else if (rtrn && !grant && cnt != 4'd0)
      nxt = cnt - 4'd1;
    return nxt;
  endfunction

  // The slot bypasses on ready so a grant can land in the same edge the old entry leaves.
  assign slot_free = !mem_valid_q || bus.mem_ready_i;
  assign elig_i    = bus.icache_req_i && (cnt_i_q < Limit);
  assign elig_d    = bus.dcache_req_i && (cnt_d_q < Limit);

  // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    rr_d  = rr_q;
    // Acks must drop while reset is held, even though the cleared state would look grantable.
    if (slot_free && !rst_i) begin
      if (elig_i && elig_d) begin
        gnt_i = (rr_q == SRC_I);
        gnt_d = (rr_q == SRC_D);
      end else begin
        gnt_i = elig_i;
        gnt_d = elig_d;
      end
    end
    if (gnt_i)
      rr_d = SRC_D;
    else if (gnt_d)
      rr_d = SRC_I;
  end

  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_data_d  = mem_data_q;
    mem_src_d   = mem_src_q;
    if (gnt_i || gnt_d) begin
      mem_valid_d = 1'b1;
      mem_data_d  = gnt_d ? bus.dcache_data_i : bus.icache_data_i;
      mem_src_d   = gnt_d ? SRC_D : SRC_I;
    end else if (bus.mem_ready_i) begin
      mem_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_i_d = credit_next(cnt_i_q, gnt_i, bus.icache_rtrn_i);
    cnt_d_d = credit_next(cnt_d_q, gnt_d, bus.dcache_rtrn_i);
    err_d   = err_q
            | (bus.icache_rtrn_i && cnt_i_q == 4'd0)
            | (bus.dcache_rtrn_i && cnt_d_q == 4'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_i_q     <= 4'd0;
      cnt_d_q     <= 4'd0;
      rr_q        <= SRC_I;
      mem_valid_q <= 1'b0;
      mem_data_q  <= '0;
      mem_src_q   <= SRC_I;
      err_q       <= 1'b0;
    end else begin
      cnt_i_q     <= cnt_i_d;
      cnt_d_q     <= cnt_d_d;
      rr_q        <= rr_d;
      mem_valid_q <= mem_valid_d;
      mem_data_q  <= mem_data_d;
      mem_src_q   <= mem_src_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    bus.icache_ack_o = gnt_i;
    bus.dcache_ack_o = gnt_d;
    bus.mem_valid_o  = mem_valid_q;
    bus.mem_data_o   = mem_data_q;
    bus.mem_src_o    = mem_src_q;
    idle_o           = (cnt_i_q == 4'd0) && (cnt_d_q == 4'd0) && !mem_valid_q;
    err_o            = err_q;
  end

`ifdef WT_ARB_STATS_EN
  logic [31:0] stat_i_q, stat_i_d;
  logic [31:0] stat_d_q, stat_d_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stat_i_d = stat_i_q;
    stat_d_d = stat_d_q;
    stall_d  = stall_q;
    if (gnt_i && stat_i_q != '1)
      stat_i_d = stat_i_q + 32'd1;
    if (gnt_d && stat_d_q != '1)
      stat_d_d = stat_d_q + 32'd1;
    if (mem_valid_q && !bus.mem_ready_i && stall_q != '1)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_i_q <= '0;
      stat_d_q <= '0;
      stall_q  <= '0;
    end else begin
      stat_i_q <= stat_i_d;
      stat_d_q <= stat_d_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_icache_o = stat_i_q;
  assign stat_dcache_o = stat_d_q;
  assign stat_stall_o  = stall_q;
`endif

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Self-checking bench for wt_mem_req_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_wt_mem_req_arbiter;
  localparam int DW  = 128;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic idle, err;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wt_mem_req_arbiter_if #(.DataWidth(DW)) bus ();

`ifdef WT_ARB_STATS_EN
  logic [31:0] st_i, st_d, st_s;
`endif

  wt_mem_req_arbiter #(
    .DataWidth(DW),
    .MaxOutstanding(MAX)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .idle_o(idle),
    .err_o (err)
`ifdef WT_ARB_STATS_EN
    ,
    .stat_icache_o(st_i),
    .stat_dcache_o(st_d),
    .stat_stall_o (st_s)
`endif
  );

  // Behavioural model state: credits per source, preferred source, output slot, sticky error.
  int             m_cnt[2];
  int             m_pref;
  bit             m_valid;
  logic [DW-1:0]  m_data;
  int             m_src;
  bit             m_err;
  longint         m_stat[2];
  longint         m_stall;

  function automatic logic [DW-1:0] rand_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_reset();
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_pref   = 0;
    m_valid  = 0;
    m_data   = '0;
    m_src    = 0;
    m_err    = 0;
    m_stat[0] = 0; m_stat[1] = 0;
    m_stall  = 0;
  endfunction

  // Winner for the current cycle: -1 none, 0 I$, 1 D$.
  function automatic int model_winner();
    bit free, e0, e1;
    free = !m_valid || bus.mem_ready_i;
    e0   = bus.icache_req_i && (m_cnt[0] < MAX);
    e1   = bus.dcache_req_i && (m_cnt[1] < MAX);
    if (!free) return -1;
    if (e0 && e1) return m_pref;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic void model_commit(input int w);
    int r[2];
    int g;
    r[0] = bus.icache_rtrn_i ? 1 : 0;
    r[1] = bus.dcache_rtrn_i ? 1 : 0;
    if (m_valid && !bus.mem_ready_i) m_stall++;
    if (w >= 0) begin
      m_valid = 1;
      m_data  = (w == 1) ? bus.dcache_data_i : bus.icache_data_i;
      m_src   = w;
      m_pref  = 1 - w;
      m_stat[w]++;
    end else if (bus.mem_ready_i) begin
      m_valid = 0;
    end
    for (int s = 0; s < 2; s++) begin
      if (r[s] == 1 && m_cnt[s] == 0) m_err = 1;
      g = (w == s) ? 1 : 0;
      m_cnt[s] = m_cnt[s] + g - r[s];
      if (m_cnt[s] < 0) m_cnt[s] = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.icache_req_i  = 1'b0;
    bus.dcache_req_i  = 1'b0;
    bus.icache_data_i = '0;
    bus.dcache_data_i = '0;
    bus.mem_ready_i   = 1'b1;
    bus.icache_rtrn_i = 1'b0;
    bus.dcache_rtrn_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.icache_req_i  = 1'b1;
    bus.dcache_req_i  = 1'b1;
    bus.icache_data_i = rand_payload();
    bus.dcache_data_i = rand_payload();
    repeat (3) begin
      @(posedge clk);
      #2;
      checks++;
      if (bus.icache_ack_o !== 1'b0 || bus.dcache_ack_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_acks: got i=%b d=%b expected 0 0", bus.icache_ack_o, bus.dcache_ack_o);
      end
      checks++;
      if (bus.mem_valid_o !== 1'b0 || idle !== 1'b1 || err !== 1'b0) begin
        failures++;
        $display("FAIL reset_state: got valid=%b idle=%b err=%b expected 0 1 0", bus.mem_valid_o, idle, err);
      end
      checks++;
      if (bus.mem_data_o !== '0 || bus.mem_src_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_out: got data=%0h src=%b expected 0 0", bus.mem_data_o, bus.mem_src_o);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.icache_ack_o !== 1'b1 || bus.dcache_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_grant: got i=%b d=%b expected 1 0", bus.icache_ack_o, bus.dcache_ack_o);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int cnt[2];
    bit ack_i, ack_d;
    cnt[0] = 0; cnt[1] = 0;
    do_reset();
    bus.icache_req_i  = 1'b1;
    bus.dcache_req_i  = 1'b1;
    bus.icache_data_i = rand_payload();
    bus.dcache_data_i = rand_payload();
    for (int k = 0; k < 12; k++) begin
      bus.icache_rtrn_i = (cnt[0] > 0);
      bus.dcache_rtrn_i = (cnt[1] > 0);
      #2;
      checks++;
      if (bus.icache_ack_o !== (k % 2 == 0) || bus.dcache_ack_o !== (k % 2 == 1)) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got i=%b d=%b expected i=%b d=%b", k,
                 bus.icache_ack_o, bus.dcache_ack_o, (k % 2 == 0), (k % 2 == 1));
      end
      if (k > 0) begin
        checks++;
        if (bus.mem_valid_o !== 1'b1 || bus.mem_src_o !== ((k - 1) % 2 == 1)) begin
          failures++;
          $display("FAIL rr_src[%0d]: got valid=%b src=%b expected 1 %b", k,
                   bus.mem_valid_o, bus.mem_src_o, ((k - 1) % 2 == 1));
        end
      end
      ack_i = bus.icache_ack_o;
      ack_d = bus.dcache_ack_o;
      tick();
      cnt[0] = cnt[0] + (ack_i ? 1 : 0) - (bus.icache_rtrn_i ? 1 : 0);
      cnt[1] = cnt[1] + (ack_d ? 1 : 0) - (bus.dcache_rtrn_i ? 1 : 0);
      if (ack_i) bus.icache_data_i = rand_payload();
      if (ack_d) bus.dcache_data_i = rand_payload();
    end
    idle_inputs();
  endtask

  task automatic test_credit_limit();
    int acks;
    do_reset();
    bus.dcache_req_i  = 1'b1;
    bus.dcache_data_i = rand_payload();
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      #2;
      if (bus.dcache_ack_o === 1'b1) acks++;
      tick();
    end
    checks++;
    if (acks !== MAX) begin
      failures++;
      $display("FAIL credit_limit: got %0d grants expected %0d", acks, MAX);
    end
    acks = 0;
    bus.dcache_rtrn_i = 1'b1;
    #2;
    if (bus.dcache_ack_o === 1'b1) acks++;
    tick();
    bus.dcache_rtrn_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      if (bus.dcache_ack_o === 1'b1) acks++;
      tick();
    end
    checks++;
    if (acks !== 1) begin
      failures++;
      $display("FAIL credit_release: got %0d grants expected 1", acks);
    end
    checks++;
    if (idle !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL credit_status: got idle=%b err=%b expected 0 0", idle, err);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] first_p, next_p;
    first_p = DW'(8'hA5);
    next_p  = rand_payload();
    do_reset();
    bus.icache_req_i  = 1'b1;
    bus.icache_data_i = first_p;
    bus.mem_ready_i   = 1'b0;
    #2;
    checks++;
    if (bus.icache_ack_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_first_ack: got %b expected 1", bus.icache_ack_o);
    end
    tick();
    bus.icache_data_i = next_p;
    for (int k = 0; k < 5; k++) begin
      #2;
      checks++;
      if (bus.mem_data_o !== first_p || bus.mem_valid_o !== 1'b1 || bus.icache_ack_o !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got data=%0h valid=%b ack=%b expected %0h 1 0", k,
                 bus.mem_data_o, bus.mem_valid_o, bus.icache_ack_o, first_p);
      end
      tick();
    end
    bus.mem_ready_i = 1'b1;
    #2;
    checks++;
    if (bus.icache_ack_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_ack: got %b expected 1", bus.icache_ack_o);
    end
    tick();
    bus.icache_req_i = 1'b0;
    #2;
    checks++;
    if (bus.mem_data_o !== next_p || bus.mem_valid_o !== 1'b1 || bus.mem_src_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_next: got data=%0h valid=%b src=%b expected %0h 1 0",
               bus.mem_data_o, bus.mem_valid_o, bus.mem_src_o, next_p);
    end
    idle_inputs();
  endtask

  task automatic test_grant_and_return();
    int acks;
    do_reset();
    bus.dcache_req_i  = 1'b1;
    bus.dcache_data_i = rand_payload();
    for (int k = 0; k < 2; k++) begin
      #2;
      checks++;
      if (bus.dcache_ack_o !== 1'b1) begin
        failures++;
        $display("FAIL gr_setup[%0d]: got %b expected 1", k, bus.dcache_ack_o);
      end
      tick();
    end
    bus.dcache_rtrn_i = 1'b1;
    #2;
    checks++;
    if (bus.dcache_ack_o !== 1'b1) begin
      failures++;
      $display("FAIL gr_same_cycle_ack: got %b expected 1", bus.dcache_ack_o);
    end
    tick();
    bus.dcache_rtrn_i = 1'b0;
    bus.dcache_req_i  = 1'b0;
    #2;
    checks++;
    if (idle !== 1'b0) begin
      failures++;
      $display("FAIL gr_idle: got %b expected 0", idle);
    end
    // Two credits held means exactly two more grants before the limit.
    bus.dcache_req_i = 1'b1;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      #2;
      if (bus.dcache_ack_o === 1'b1) acks++;
      tick();
    end
    checks++;
    if (acks !== MAX - 2) begin
      failures++;
      $display("FAIL gr_count: got %0d further grants expected %0d", acks, MAX - 2);
    end
    idle_inputs();
  endtask

  task automatic test_underflow();
    int acks;
    do_reset();
    bus.icache_rtrn_i = 1'b1;
    #2;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL uf_before: got err=%b expected 0", err);
    end
    tick();
    bus.icache_rtrn_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++;
      if (err !== 1'b1 || idle !== 1'b1) begin
        failures++;
        $display("FAIL uf_sticky[%0d]: got err=%b idle=%b expected 1 1", k, err, idle);
      end
      tick();
    end
    bus.icache_req_i  = 1'b1;
    bus.icache_data_i = rand_payload();
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      #2;
      if (bus.icache_ack_o === 1'b1) acks++;
      tick();
    end
    checks++;
    if (acks !== MAX || err !== 1'b1) begin
      failures++;
      $display("FAIL uf_count: got grants=%0d err=%b expected %0d 1", acks, err, MAX);
    end
`ifdef WT_ARB_STATS_EN
    checks++;
    if (st_i !== 32'(MAX) || st_d !== 32'd0 || st_s !== 32'd0) begin
      failures++;
      $display("FAIL uf_stats: got i=%0d d=%0d stall=%0d expected %0d 0 0", st_i, st_d, st_s, MAX);
    end
`endif
    idle_inputs();
  endtask

  task automatic test_random();
    bit pend[2];
    int w;
    int shown;
    pend[0] = 0; pend[1] = 0;
    shown = 0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if (!pend[0] && $urandom_range(0, 9) < 6) begin
        pend[0] = 1;
        bus.icache_data_i = rand_payload();
      end
      if (!pend[1] && $urandom_range(0, 9) < 6) begin
        pend[1] = 1;
        bus.dcache_data_i = rand_payload();
      end
      bus.icache_req_i  = pend[0];
      bus.dcache_req_i  = pend[1];
      bus.mem_ready_i   = ($urandom_range(0, 3) != 0);
      bus.icache_rtrn_i = (m_cnt[0] > 0) && ($urandom_range(0, 2) == 0);
      bus.dcache_rtrn_i = (m_cnt[1] > 0) && ($urandom_range(0, 2) == 0);
      #2;
      w = model_winner();
      checks++;
      if (bus.icache_ack_o !== (w == 0) || bus.dcache_ack_o !== (w == 1)) begin
        failures++;
        if (shown++ < 20)
          $display("FAIL rnd_ack[%0d]: got i=%b d=%b expected i=%b d=%b", k,
                   bus.icache_ack_o, bus.dcache_ack_o, (w == 0), (w == 1));
      end
      checks++;
      if (bus.mem_valid_o !== m_valid || (m_valid && (bus.mem_data_o !== m_data || bus.mem_src_o !== (m_src == 1)))) begin
        failures++;
        if (shown++ < 20)
          $display("FAIL rnd_out[%0d]: got valid=%b src=%b data=%0h expected valid=%b src=%0d data=%0h", k,
                   bus.mem_valid_o, bus.mem_src_o, bus.mem_data_o, m_valid, m_src, m_data);
      end
      checks++;
      if (idle !== (m_cnt[0] == 0 && m_cnt[1] == 0 && !m_valid) || err !== m_err) begin
        failures++;
        if (shown++ < 20)
          $display("FAIL rnd_status[%0d]: got idle=%b err=%b expected idle=%b err=%b", k,
                   idle, err, (m_cnt[0] == 0 && m_cnt[1] == 0 && !m_valid), m_err);
      end
      model_commit(w);
      if (w >= 0) pend[w] = 0;
      tick();
    end
`ifdef WT_ARB_STATS_EN
    #2;
    checks++;
    if (st_i !== 32'(m_stat[0]) || st_d !== 32'(m_stat[1]) || st_s !== 32'(m_stall)) begin
      failures++;
      $display("FAIL rnd_stats: got i=%0d d=%0d stall=%0d expected %0d %0d %0d",
               st_i, st_d, st_s, m_stat[0], m_stat[1], m_stall);
    end
`endif
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_backpressure();
    test_grant_and_return();
    test_underflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wt_mem_req_arbiter.md
Name: wt_mem_req_arbiter

Overview:
- Merges the I$ and D$ memory request channels (req/ack style, request held until acked) into one valid/ready request stream toward the memory adapter.
- Arbitration is round-robin, and each source has its own outstanding-transaction credit limit.
- One output register decouples the caches from adapter backpressure.
- Return pulses from the adapter side release credits.

Parameters:
- DataWidth, 128, width of the request payload (opaque packed cache request).
- MaxOutstanding, 4, maximum in-flight requests per source (range 1..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- icache_req_i  in  1  I$ request pending; held until icache_ack_o
- icache_ack_o  out  1  one-cycle grant pulse to I$
- icache_data_i  in  DataWidth  I$ request payload
- dcache_req_i  in  1  D$ request pending; held until dcache_ack_o
- dcache_ack_o  out  1  one-cycle grant pulse to D$
- dcache_data_i  in  DataWidth  D$ request payload
- mem_valid_o  out  1  output register holds a request
- mem_ready_i  in  1  adapter accepts the request
- mem_data_o  out  DataWidth  registered payload
- mem_src_o  out  1  source of the registered request: 0=I$, 1=D$
- icache_rtrn_i  in  1  one I$ transaction completed (credit release)
- dcache_rtrn_i  in  1  one D$ transaction completed
- idle_o  out  1  no credits in use and output register empty
- err_o  out  1  sticky: a return arrived with a zero credit count

Behaviour:
- Reset values:
  - mem_valid_o=0, mem_data_o=0, mem_src_o=0.
  - Acks 0, credit counters 0, RR pointer=I$ preferred.
  - err_o=0, idle_o=1.
- Slot free condition: !mem_valid_o | mem_ready_i. Bypass on ready, so back-to-back grants sustain one request per cycle.
- Eligibility: src_req & (cnt_src < MaxOutstanding).
- Grant happens only when the slot is free and at least one source is eligible:
  - If both are eligible, the source indicated by the RR pointer wins. The pointer then points at the other source.
  - If only one is eligible, it wins. The pointer moves to the other source.
  - With no grant, the pointer holds.
- Grant cycle:
  - The winner's ack is asserted combinationally (at most one ack per cycle).
  - The payload and source are captured at the clock edge.
  - mem_valid_o=1 in the following cycle. Latency req->mem_valid_o is 1 cycle minimum.
- Output register:
  - Cleared (valid=0) on mem_ready_i & mem_valid_o when there is no new grant.
  - mem_data_o and mem_src_o hold stable while mem_valid_o & !mem_ready_i.
- Credits, per source, 4-bit counter:
  - +1 on grant, -1 on rtrn. Both in the same cycle: unchanged.
  - rtrn with count 0: counter stays 0 and err_o is set until reset.
  - Count never exceeds MaxOutstanding. A source at the limit is not granted even if the other source is idle.
- A request deasserted without an ack is a protocol violation. The block does not depend on it: grant is evaluated per cycle.
- idle_o = (cnt_i==0) & (cnt_d==0) & !mem_valid_o, combinational.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). In-flight credits are discarded. Acks drop in the same cycle.

Optional Feature:
- Macro: WT_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_icache_o [31:0] and stat_dcache_o [31:0] counting grants per source. They saturate at 0xFFFFFFFF and reset to 0.
  - Adds stat_stall_o [31:0] counting cycles with mem_valid_o & !mem_ready_i, also saturating.
- When undefined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_i with requests high, release.
  - Response: no acks during reset, mem_valid_o=0, idle_o=1, err_o=0. The first grant after release goes to I$ when both request.
- Round-robin:
  - Stimulus: both sources request continuously, mem_ready_i=1, MaxOutstanding=4, returns pulsed each cycle.
  - Response: grants alternate I,D,I,D. mem_src_o is 0,1,0,1 one cycle later. One mem_valid_o per cycle.
- Credit limit:
  - Stimulus: D$ only requests, no returns, MaxOutstanding=4.
  - Response: exactly 4 dcache_ack_o pulses, then none. One dcache_rtrn_i pulse produces exactly one further grant.
- Backpressure:
  - Stimulus: mem_ready_i=0 for 5 cycles with payload 0xA5 registered and I$ requesting.
  - Response: mem_data_o stays 0xA5 and icache_ack_o=0. On the ready cycle the I$ ack fires, and the new payload appears next cycle with no bubble.
- Simultaneous grant and return:
  - Stimulus: D$ count=2, grant and dcache_rtrn_i in the same cycle.
  - Response: count stays 2 and idle_o=0.
- Underflow:
  - Stimulus: icache_rtrn_i with I$ count 0.
  - Response: err_o=1 and stays 1, count stays 0. With WT_ARB_STATS_EN, the stat counters are unaffected.
